// File: rtl/alu_pipe_nbit.sv
// Carry-segmented pipelined ALU: one SEG_W-bit slice per stage, carry registered between stages.
// Optional flag outputs (zero/neg/ovf) are built only when ALU_FLAGS_EN is defined.
module alu_pipe_nbit #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic [3:0]       sel_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] f_o,
    output logic             cout_o,
    output logic             zero_o,
    output logic             neg_o,
    output logic             ovf_o
);

    localparam int NSEG = WIDTH / SEG_W;
    localparam int NREG = (NSEG > 1) ? NSEG - 1 : 1;
    localparam int LAST = NSEG - 1;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_PASS = 4'b0110;
    localparam logic [3:0] OP_NOT  = 4'b0111;
    localparam logic [3:0] OP_INC  = 4'b1000;
    localparam logic [3:0] OP_DEC  = 4'b1001;

    if (SEG_W < 1 || WIDTH % SEG_W != 0 || NSEG < 1) begin : g_bad_params
        $error("alu_pipe_nbit: WIDTH must be a non-zero multiple of SEG_W");
    end

    // Inter-stage registers: entry k feeds stage k+1.
    logic [NREG-1:0]  vld_q;
    logic [3:0]       op_q [NREG];
    logic [WIDTH-1:0] a_q  [NREG];
    logic [WIDTH-1:0] b_q  [NREG];
    logic [WIDTH-1:0] r_q  [NREG];
    logic             c_q  [NREG];

    logic             st_v  [NSEG];
    logic [3:0]       st_op [NSEG];
    logic [WIDTH-1:0] st_a  [NSEG];
    logic [WIDTH-1:0] st_b  [NSEG];
    logic [WIDTH-1:0] st_r  [NSEG];
    logic             st_c  [NSEG];
    logic [WIDTH-1:0] nx_r  [NSEG];
    logic             nx_c  [NSEG];

    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic             advance;
    logic             out_valid_q;
    logic [WIDTH-1:0] f_q;
    logic             cout_q;

    assign advance     = out_ready_i | ~out_valid_q;
    assign in_ready_o  = advance;
    assign out_valid_o = out_valid_q;
    assign f_o         = f_q;
    assign cout_o      = cout_q;

    // SUB, INC and DEC are folded into a plain add once, at entry.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        b_eff = b_i;
        c_eff = 1'b0;
        case (sel_i)
            OP_ADD: c_eff = cin_i;
            OP_SUB: begin b_eff = ~b_i; c_eff = cin_i; end
            OP_INC: begin b_eff = '0;   c_eff = 1'b1;  end
            OP_DEC: b_eff = '1;
            default: ;
        endcase
    end

    always_comb begin
        st_v[0]  = in_valid_i;
        st_op[0] = sel_i;
        st_a[0]  = a_i;
        st_b[0]  = b_eff;
        st_r[0]  = '0;
        st_c[0]  = c_eff;
        for (int k = 1; k < NSEG; k++) begin
            st_v[k]  = vld_q[k-1];
            st_op[k] = op_q[k-1];
            st_a[k]  = a_q[k-1];
            st_b[k]  = b_q[k-1];
            st_r[k]  = r_q[k-1];
            st_c[k]  = c_q[k-1];
        end
    end

    always_comb begin
        logic [SEG_W-1:0] sa, sb, sr;
        logic             co;
        for (int k = 0; k < NSEG; k++) begin
            sa = st_a[k][k*SEG_W +: SEG_W];
            sb = st_b[k][k*SEG_W +: SEG_W];
            sr = '0;
            co = 1'b0;
            case (st_op[k])
                OP_ADD, OP_SUB, OP_INC, OP_DEC:
                    {co, sr} = {1'b0, sa} + {1'b0, sb} + {{SEG_W{1'b0}}, st_c[k]};
                OP_AND:  sr = sa & sb;
                OP_OR:   sr = sa | sb;
                OP_XOR:  sr = sa ^ sb;
                OP_NOR:  sr = ~(sa | sb);
                OP_PASS: sr = sa;
                OP_NOT:  sr = ~sa;
                default: ;
            endcase
            nx_r[k] = st_r[k];
            nx_r[k][k*SEG_W +: SEG_W] = sr;
            nx_c[k] = co;
        end
    end

    // NOTE: payload registers carry no reset; only the valid bits and visible outputs need one.
    always_ff @(posedge clk_i) begin
        if (advance) begin
            for (int k = 0; k < NSEG - 1; k++) begin
                op_q[k] <= st_op[k];
                a_q[k]  <= st_a[k];
                b_q[k]  <= st_b[k];
                r_q[k]  <= nx_r[k];
                c_q[k]  <= nx_c[k];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            f_q         <= '0;
            cout_q      <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < NSEG - 1; k++) vld_q[k] <= st_v[k];
            out_valid_q <= st_v[LAST];
            if (st_v[LAST]) begin
                f_q    <= nx_r[LAST];
                cout_q <= nx_c[LAST];
            end
        end
    end

`ifdef ALU_FLAGS_EN
    logic zero_q, neg_q, ovf_q, ovf_nx, arith_last;

    assign arith_last = (st_op[LAST] == OP_ADD) || (st_op[LAST] == OP_SUB) ||
                        (st_op[LAST] == OP_INC) || (st_op[LAST] == OP_DEC);
    // Same-sign addends giving a differently-signed sum is carry-in(MSB) ^ carry-out(MSB).
    assign ovf_nx = arith_last && (st_a[LAST][WIDTH-1] == st_b[LAST][WIDTH-1]) &&
                    (nx_r[LAST][WIDTH-1] != st_a[LAST][WIDTH-1]);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (advance && st_v[LAST]) begin
            zero_q <= (nx_r[LAST] == '0);
            neg_q  <= nx_r[LAST][WIDTH-1];
            ovf_q  <= ovf_nx;
        end
    end

    assign zero_o = zero_q;
    assign neg_o  = neg_q;
    assign ovf_o  = ovf_q;
`else
    assign zero_o = 1'b0;
    assign neg_o  = 1'b0;
    assign ovf_o  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_pipe_nbit.sv
// Self-checking bench for alu_pipe_nbit: three parameterisations against an arithmetic model.
// Flag expectations follow ALU_FLAGS_EN.
module tb_alu_pipe_nbit;

`ifdef ALU_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    typedef struct {
        longint unsigned f;
        bit cout;
        bit zero;
        bit neg;
        bit ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst, in_valid, out_ready, cin;
    logic [3:0] sel;
    logic [31:0] a0, b0, f0;
    logic [15:0] a1, b1, f1;
    logic [7:0]  a2, b2, f2;
    logic in_ready0, in_ready1, in_ready2;
    logic out_valid0, out_valid1, out_valid2;
    logic cout0, cout1, cout2, zero0, zero1, zero2, neg0, neg1, neg2, ovf0, ovf1, ovf2;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t q0[$], q1[$], q2[$];

    always #5 clk = ~clk;

    alu_pipe_nbit #(.WIDTH(32), .SEG_W(8)) dut0 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready0),
        .a_i(a0), .b_i(b0), .cin_i(cin), .sel_i(sel), .out_valid_o(out_valid0),
        .out_ready_i(out_ready), .f_o(f0), .cout_o(cout0), .zero_o(zero0), .neg_o(neg0), .ovf_o(ovf0));

    alu_pipe_nbit #(.WIDTH(16), .SEG_W(4)) dut1 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready1),
        .a_i(a1), .b_i(b1), .cin_i(cin), .sel_i(sel), .out_valid_o(out_valid1),
        .out_ready_i(out_ready), .f_o(f1), .cout_o(cout1), .zero_o(zero1), .neg_o(neg1), .ovf_o(ovf1));

    alu_pipe_nbit #(.WIDTH(8), .SEG_W(8)) dut2 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready2),
        .a_i(a2), .b_i(b2), .cin_i(cin), .sel_i(sel), .out_valid_o(out_valid2),
        .out_ready_i(out_ready), .f_o(f2), .cout_o(cout2), .zero_o(zero2), .neg_o(neg2), .ovf_o(ovf2));

    // Reference: integer arithmetic on unsigned values, overflow from the signed interpretation.
    function automatic exp_t model(int w, logic [3:0] op, longint unsigned a, longint unsigned b, bit cin_v);
        exp_t e;
        longint unsigned mask, half, bx, s;
        longint sa, sb, ssum;
        bit arith, ci;
        mask = (64'd1 << w) - 1;
        half = 64'd1 << (w - 1);
        a = a & mask;
        b = b & mask;
        bx = b;
        ci = cin_v;
        arith = 1'b1;
        e = '{default: 0};
        case (op)
            4'd0: ;
            4'd1: bx = ~b & mask;
            4'd8: begin bx = 0; ci = 1'b1; end
            4'd9: begin bx = mask; ci = 1'b0; end
            default: arith = 1'b0;
        endcase
        if (arith) begin
            s = a + bx + 64'(ci);
            e.f = s & mask;
            e.cout = ((s >> w) & 64'd1) != 0;
            sa = longint'(a) - ((a >= half) ? longint'(mask) + 1 : 0);
            sb = longint'(bx) - ((bx >= half) ? longint'(mask) + 1 : 0);
            ssum = sa + sb + longint'(ci);
            e.ovf = (ssum > longint'(half) - 1) || (ssum < -longint'(half));
        end else begin
            case (op)
                4'd2: e.f = a & b;
                4'd3: e.f = a | b;
                4'd4: e.f = a ^ b;
                4'd5: e.f = ~(a | b) & mask;
                4'd6: e.f = a;
                4'd7: e.f = ~a & mask;
                default: e.f = 0;
            endcase
        end
        e.zero = FLAGS && (e.f == 0);
        e.neg  = FLAGS && (((e.f >> (w - 1)) & 64'd1) != 0);
        e.ovf  = FLAGS && e.ovf;
        return e;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_beat(string tag, exp_t e, logic [63:0] f, logic c, logic z, logic n, logic o);
        check({tag, "_f"}, f, e.f);
        check({tag, "_cout"}, 64'(c), 64'(e.cout));
        check({tag, "_zero"}, 64'(z), 64'(e.zero));
        check({tag, "_neg"}, 64'(n), 64'(e.neg));
        check({tag, "_ovf"}, 64'(o), 64'(e.ovf));
    endtask

    task automatic set_ops(logic [3:0] s, logic [31:0] a, logic [31:0] b, bit c);
        sel = s;
        a0 = a;        b0 = b;
        a1 = a[15:0];  b1 = b[15:0];
        a2 = a[7:0];   b2 = b[7:0];
        cin = c;
    endtask

    task automatic rand_beat(logic [3:0] s);
        set_ops(s, $urandom, $urandom, 1'($urandom_range(0, 1)));
    endtask

    // One clock: record accepted inputs, score delivered outputs, then advance past the edge.
    task automatic tick();
        #1;
        if (in_valid && in_ready0) q0.push_back(model(32, sel, a0, b0, cin));
        if (in_valid && in_ready1) q1.push_back(model(16, sel, a1, b1, cin));
        if (in_valid && in_ready2) q2.push_back(model(8, sel, a2, b2, cin));
        if (out_valid0 && out_ready) begin
            if (q0.size() == 0) check("d0_spurious_out", 64'(out_valid0), 0);
            else cmp_beat("d0", q0.pop_front(), 64'(f0), cout0, zero0, neg0, ovf0);
        end
        if (out_valid1 && out_ready) begin
            if (q1.size() == 0) check("d1_spurious_out", 64'(out_valid1), 0);
            else cmp_beat("d1", q1.pop_front(), 64'(f1), cout1, zero1, neg1, ovf1);
        end
        if (out_valid2 && out_ready) begin
            if (q2.size() == 0) check("d2_spurious_out", 64'(out_valid2), 0);
            else cmp_beat("d2", q2.pop_front(), 64'(f2), cout2, zero2, neg2, ovf2);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (8) tick();
        check("drain_q0", 64'(q0.size()), 0);
        check("drain_q1", 64'(q1.size()), 0);
        check("drain_q2", 64'(q2.size()), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, t, k, gap, first_t;
        logic [31:0] held0;
        logic [15:0] held1;
        logic [7:0]  held2;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        set_ops(4'd0, 0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid0), 0);
        check("rst_f", 64'(f0), 0);
        check("rst_cout", 64'(cout0), 0);
        check("rst_in_ready", 64'(in_ready0), 1);
        check("rst_out_valid_nseg1", 64'(out_valid2), 0);
        rst = 1'b0;

        // ADD carry chain through every segment
        set_ops(4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        in_valid = 1'b1;
        tick();
        check("t1_latency_nseg1", 64'(out_valid2), 1);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid0 && n < 20) begin tick(); n++; end
        check("t1_latency", 64'(n), 3);
        check("t1_f", 64'(f0), 0);
        check("t1_cout", 64'(cout0), 1);
        check("t1_zero", 64'(zero0), 64'(FLAGS));
        check("t1_ovf", 64'(ovf0), 0);
        drain();

        // SUB signed overflow
        set_ops(4'b0001, 32'h8000_0000, 32'h0000_0001, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid0 && n < 20) begin tick(); n++; end
        check("t2_latency", 64'(n), 3);
        check("t2_f", 64'(f0), 64'h7FFF_FFFF);
        check("t2_cout", 64'(cout0), 1);
        check("t2_ovf", 64'(ovf0), 64'(FLAGS));
        check("t2_neg", 64'(neg0), 0);
        drain();

        // Back-to-back streaming, no bubbles
        first_t = -1; k = 0; gap = 0; t = 0;
        for (int i = 0; i < 16; i++) begin
            if (i < 8) begin
                set_ops(4'b0000, 32'(i), 32'(i), 1'b0);
                in_valid = 1'b1;
                check("t3_in_ready", 64'(in_ready0), 1);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            t++;
            if (out_valid0) begin
                if (first_t < 0) first_t = t;
                check("t3_f", 64'(f0), 64'(2 * k));
                k++;
            end else if (k > 0 && k < 8) begin
                gap++;
            end
        end
        check("t3_first", 64'(first_t), 4);
        check("t3_count", 64'(k), 8);
        check("t3_gap", 64'(gap), 0);
        drain();

        // Back-pressure: stall a full pipe, then release
        out_ready = 1'b1;
        repeat (6) begin rand_beat(4'($urandom_range(0, 9))); in_valid = 1'b1; tick(); end
        out_ready = 1'b0;
        held0 = f0; held1 = f1; held2 = f2;
        check("t4_full", 64'(out_valid0), 1);
        repeat (5) begin
            rand_beat(4'($urandom_range(0, 9)));
            in_valid = 1'b1;
            tick();
            check("t4_in_ready", 64'(in_ready0), 0);
            check("t4_in_ready_d1", 64'(in_ready1), 0);
            check("t4_out_valid", 64'(out_valid0), 1);
            check("t4_hold_f0", 64'(f0), 64'(held0));
            check("t4_hold_f1", 64'(f1), 64'(held1));
            check("t4_hold_f2", 64'(f2), 64'(held2));
        end
        drain();

        // Reset while stalled with beats in flight
        out_ready = 1'b0;
        repeat (6) begin rand_beat(4'b0000); a0[31] = 1'b1; in_valid = 1'b1; tick(); end
        check("t5_pre_valid", 64'(out_valid0), 1);
        rst = 1'b1;
        #1;
        check("t5_out_valid", 64'(out_valid0), 0);
        check("t5_f", 64'(f0), 0);
        check("t5_cout", 64'(cout0), 0);
        check("t5_flags", 64'({zero0, neg0, ovf0}), 0);
        check("t5_in_ready", 64'(in_ready0), 1);
        check("t5_out_valid_nseg1", 64'(out_valid2), 0);
        check("t5_f_nseg1", 64'(f2), 0);
        q0.delete(); q1.delete(); q2.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (8) begin
            tick();
            check("t5_no_ghost", 64'({out_valid0, out_valid1, out_valid2}), 0);
        end

        // Opcode sweep, then random traffic with random back-pressure
        for (int op = 0; op < 16; op++) begin
            rand_beat(4'(op));
            in_valid = 1'b1;
            out_ready = 1'b1;
            tick();
        end
        drain();
        for (int i = 0; i < 600; i++) begin
            rand_beat(4'($urandom_range(0, 15)));
            in_valid = ($urandom_range(0, 9) < 8);
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
